// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register: operation encodings.
package universal_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_LOAD   = 3'b001,
        MODE_SHL    = 3'b010,
        MODE_SHR    = 3'b011,
        MODE_ROL    = 3'b100,
        MODE_ROR    = 3'b101,
        MODE_CNT_UP = 3'b110,
        MODE_CNT_DN = 3'b111
    } mode_e;

endpackage

// File: rtl/universal_register_dff_cell.sv
// Single storage bit: rising-edge flop with active-low asynchronous clear and preset.
module dff_cell (
    input  logic CLK,
    input  logic PRE,
    input  logic CLR,
    input  logic D,
    output logic Q,
    output logic nQ
);

    // Clear wins if both asynchronous inputs are asserted together.
    always_ff @(posedge CLK or negedge CLR or negedge PRE) begin
        if (!CLR) begin
            Q <= 1'b0;
        end else if (!PRE) begin
            Q <= 1'b1;
        end else begin
            Q <= D;
        end
    end

    assign nQ = ~Q;

endmodule

// File: rtl/universal_register.sv
// General-purpose register: hold, load, shift, rotate and count, built from per-bit flop cells.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_LSB,
    input  logic             SI_MSB,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             TC
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] nq_reg;
    logic [WIDTH-1:0] q_next;

    // Hold unless enabled, so an unknown MODE cannot disturb Q while EN is low.
    always_comb begin
        q_next = q_reg;
        if (EN) begin
            case (MODE)
                MODE_LOAD:   q_next = D;
                MODE_SHL:    q_next = {q_reg[WIDTH-2:0], SI_LSB};
                MODE_SHR:    q_next = {SI_MSB, q_reg[WIDTH-1:1]};
                MODE_ROL:    q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                MODE_ROR:    q_next = {q_reg[0], q_reg[WIDTH-1:1]};
                MODE_CNT_UP: q_next = q_reg + WIDTH'(1);
                MODE_CNT_DN: q_next = q_reg - WIDTH'(1);
                default:     q_next = q_reg;
            endcase
        end
    end

    // Each bit routes the shared clear to preset or clear according to its reset value.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic pre_b;
        logic clr_b;

        assign pre_b = RESET_VALUE[gi] ? CLR  : 1'b1;
        assign clr_b = RESET_VALUE[gi] ? 1'b1 : CLR;

        dff_cell u_cell (
            .CLK (CLK),
            .PRE (pre_b),
            .CLR (clr_b),
            .D   (q_next[gi]),
            .Q   (q_reg[gi]),
            .nQ  (nq_reg[gi])
        );
    end

    assign Q  = q_reg;
    assign nQ = nq_reg;
    assign TC = ((MODE == MODE_CNT_UP) && (&q_reg)) ||
                ((MODE == MODE_CNT_DN) && !(|q_reg));

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench for universal_register (WIDTH=8, RESET_VALUE=8'hA5).
module tb_universal_register;

    localparam logic [7:0] RV = 8'hA5;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       EN = 1'b0;
    logic [2:0] MODE = 3'd0;
    logic [7:0] D = 8'd0;
    logic       SI_LSB = 1'b0;
    logic       SI_MSB = 1'b0;
    logic [7:0] Q;
    logic [7:0] nQ;
    logic       TC;

    int total = 0;
    int bad = 0;
    logic [7:0] model_q = RV;

    universal_register #(.WIDTH(8), .RESET_VALUE(RV)) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .EN     (EN),
        .MODE   (MODE),
        .D      (D),
        .SI_LSB (SI_LSB),
        .SI_MSB (SI_MSB),
        .Q      (Q),
        .nQ     (nQ),
        .TC     (TC)
    );

    always #5 CLK = ~CLK;

    // Reference behaviour written as plain arithmetic on the register value.
    function automatic logic [7:0] model_next(input logic [7:0] q, input int m,
                                              input logic [7:0] d, input logic sl, input logic sr);
        int v;
        v = int'(q);
        case (m)
            1: v = int'(d);
            2: v = ((v * 2) % 256) + int'(sl);
            3: v = (v / 2) + (sr ? 128 : 0);
            4: v = ((v * 2) % 256) + (v / 128);
            5: v = (v / 2) + ((v % 2) * 128);
            6: v = (v + 1) % 256;
            7: v = (v + 255) % 256;
            default: v = int'(q);
        endcase
        return v[7:0];
    endfunction

    function automatic logic model_tc(input logic [7:0] q, input int m);
        return (m == 6 && q == 8'd255) || (m == 7 && q == 8'd0);
    endfunction

    task automatic tick();
        if (EN === 1'b1 && CLR === 1'b1)
            model_q = model_next(model_q, int'(MODE), D, SI_LSB, SI_MSB);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2 CLR = 1'b0;
        #1;
        total++;
        if (Q !== RV || nQ !== ~RV) begin
            bad++;
            $display("FAIL reset_initial q=%h nq=%h exp q=%h nq=%h", Q, nQ, RV, ~RV);
        end
        @(posedge CLK); #1;
        CLR = 1'b1;
        model_q = RV;
        EN = 1'b1; MODE = 3'd6;
        tick(); tick();
        total++;
        if (Q !== 8'hA7) begin bad++; $display("FAIL reset_count q=%h exp=%h", Q, 8'hA7); end
        #2 CLR = 1'b0;
        #1;
        total++;
        if (Q !== 8'hA5 || nQ !== 8'h5A) begin
            bad++;
            $display("FAIL reset_async q=%h nq=%h exp q=a5 nq=5a", Q, nQ);
        end
        total++;
        if (TC !== 1'b0) begin bad++; $display("FAIL reset_tc tc=%b exp=0", TC); end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        total++;
        if (Q !== 8'hA5) begin bad++; $display("FAIL reset_hold q=%h exp=a5", Q); end
        CLR = 1'b1;
        model_q = RV;
        $display("test_reset: q=%h nq=%h", Q, nQ);
    endtask

    task automatic test_load_shift();
        EN = 1'b1; MODE = 3'd1; D = 8'h81; tick();
        total++;
        if (Q !== 8'h81) begin bad++; $display("FAIL load q=%h exp=81", Q); end
        MODE = 3'd2; SI_LSB = 1'b1; tick();
        total++;
        if (Q !== 8'h03) begin bad++; $display("FAIL shl q=%h exp=03", Q); end
        MODE = 3'd3; SI_MSB = 1'b0; tick();
        total++;
        if (Q !== 8'h01) begin bad++; $display("FAIL shr q=%h exp=01", Q); end
        MODE = 3'd3; SI_MSB = 1'b1; tick();
        total++;
        if (Q !== 8'h80) begin bad++; $display("FAIL shr_si q=%h exp=80", Q); end
        $display("test_load_shift: q=%h", Q);
    endtask

    task automatic test_rotate();
        EN = 1'b1; MODE = 3'd1; D = 8'h81; tick();
        MODE = 3'd4; tick();
        total++;
        if (Q !== 8'h03) begin bad++; $display("FAIL rol q=%h exp=03", Q); end
        MODE = 3'd5; tick();
        total++;
        if (Q !== 8'h81) begin bad++; $display("FAIL ror1 q=%h exp=81", Q); end
        tick();
        total++;
        if (Q !== 8'hC0) begin bad++; $display("FAIL ror2 q=%h exp=c0", Q); end
        $display("test_rotate: q=%h", Q);
    endtask

    task automatic test_count_wrap();
        EN = 1'b1; MODE = 3'd1; D = 8'hFE; tick();
        MODE = 3'd6;
        #1;
        total++;
        if (TC !== 1'b0) begin bad++; $display("FAIL tc_fe tc=%b exp=0", TC); end
        tick();
        total++;
        if (Q !== 8'hFF || TC !== 1'b1) begin bad++; $display("FAIL up_ff q=%h tc=%b exp q=ff tc=1", Q, TC); end
        tick();
        total++;
        if (Q !== 8'h00 || TC !== 1'b0) begin bad++; $display("FAIL up_wrap q=%h tc=%b exp q=00 tc=0", Q, TC); end
        MODE = 3'd7;
        #1;
        total++;
        if (TC !== 1'b1) begin bad++; $display("FAIL dn_tc tc=%b exp=1", TC); end
        tick();
        total++;
        if (Q !== 8'hFF || TC !== 1'b0) begin bad++; $display("FAIL dn_wrap q=%h tc=%b exp q=ff tc=0", Q, TC); end
        $display("test_count_wrap: q=%h", Q);
    endtask

    task automatic test_enable_gating();
        logic tc_exp;
        EN = 1'b1; MODE = 3'd1; D = 8'h3C; tick();
        EN = 1'b0; D = 8'hFF; SI_LSB = 1'b1; SI_MSB = 1'b1;
        for (int m = 0; m < 8; m++) begin
            MODE = 3'(m);
            tick();
            tc_exp = model_tc(8'h3C, m);
            total++;
            if (Q !== 8'h3C || TC !== tc_exp) begin
                bad++;
                $display("FAIL en_hold mode=%0d q=%h tc=%b exp q=3c tc=%b", m, Q, TC, tc_exp);
            end
        end
        EN = 1'b1; MODE = 3'd1; D = 8'hFF; tick();
        EN = 1'b0; MODE = 3'd6; tick();
        total++;
        if (Q !== 8'hFF || TC !== 1'b1) begin bad++; $display("FAIL en_pending q=%h tc=%b exp q=ff tc=1", Q, TC); end
        MODE = 3'bxxx; tick();
        total++;
        if (Q !== 8'hFF) begin bad++; $display("FAIL en_xmode q=%h exp=ff", Q); end
        MODE = 3'd0;
        $display("test_enable_gating: q=%h", Q);
    endtask

    task automatic test_reset_mid_count();
        EN = 1'b1; MODE = 3'd1; D = 8'h10; tick();
        MODE = 3'd6;
        tick(); tick(); tick();
        total++;
        if (Q !== 8'h13) begin bad++; $display("FAIL midcnt_pre q=%h exp=13", Q); end
        #2 CLR = 1'b0;
        #2 CLR = 1'b1;
        model_q = RV;
        #1;
        total++;
        if (Q !== 8'hA5) begin bad++; $display("FAIL midcnt_rst q=%h exp=a5", Q); end
        tick();
        total++;
        if (Q !== 8'hA6) begin bad++; $display("FAIL midcnt_next q=%h exp=a6", Q); end
        $display("test_reset_mid_count: q=%h", Q);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        EN = 1'b1; MODE = 3'd1; D = 8'h5E; tick();
        for (int i = 0; i < 300; i++) begin
            EN = ($urandom_range(0, 3) != 0);
            MODE = 3'($urandom_range(0, 7));
            D = 8'($urandom);
            SI_LSB = 1'($urandom);
            SI_MSB = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #2 CLR = 1'b0;
                #2 CLR = 1'b1;
                model_q = RV;
            end
            #1;
            total++;
            if (TC !== model_tc(model_q, int'(MODE))) begin
                bad++; errs++;
                $display("FAIL rand_tc i=%0d q=%h mode=%0d tc=%b exp=%b", i, Q, MODE, TC, model_tc(model_q, int'(MODE)));
            end
            tick();
            total++;
            if (Q !== model_q || nQ !== ~model_q) begin
                bad++; errs++;
                $display("FAIL rand_q i=%0d q=%h nq=%h exp q=%h", i, Q, nQ, model_q);
            end
        end
        $display("test_random: 300 cycles, errors=%0d", errs);
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_rotate();
        test_count_wrap();
        test_enable_gating();
        test_reset_mid_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
